// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator delta sampler.
package acc_pkg;

  localparam int unsigned ACC_W      = 32;
  localparam int unsigned DROP_CNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StPrime = ST_PRIME,
    StRun   = ST_RUN
  } fsm_state_e;

  // One queued sample: threshold-crossing flag above the wrap-safe delta.
  typedef struct packed {
    logic             cross_flag;
    logic [ACC_W-1:0] delta;
  } delta_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO; push while full is ignored unless a pop frees the slot.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q[PtrW-1:0]] <= din;
  end

endmodule

// File: rtl/acc_delta_sampler.sv
// Decimates a free-running accumulator, queues wrap-safe deltas with a threshold-crossing flag,
// and counts samples lost to a full queue.
module acc_delta_sampler
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH      = ACC_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      in_val,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      threshold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_delta,
  output logic                  out_cross,
  output logic                  full,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic [1:0]            state
);

  localparam int unsigned   CntW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0]       div_cnt_q;
  fsm_state_e            state_q;
  logic [WIDTH-1:0]      prev_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  tick, push, pop, drop;
  logic                  fifo_empty, fifo_full;
  logic [WIDTH-1:0]      delta;
  logic                  crossing;
  delta_entry_t          entry_in, entry_out;

  assign tick     = enable && (div_cnt_q == DivLast);
  assign delta    = in_val - prev_q;
  assign crossing = (prev_q < threshold) && (in_val >= threshold);
  assign entry_in = '{cross_flag: crossing, delta: delta};
  assign push     = tick && (state_q == StRun);
  assign pop      = out_valid && out_ready;
  assign drop     = push && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (RST || !enable)  div_cnt_q <= '0;
    else if (tick)       div_cnt_q <= '0;
    else                 div_cnt_q <= div_cnt_q + CntW'(1);
  end

  // Disable wins over a tick, and every re-enable re-primes prev.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      prev_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (enable) state_q <= StPrime;
        StPrime: begin
          if (!enable) state_q <= StIdle;
          else if (tick) begin
            prev_q  <= in_val;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!enable)   state_q <= StIdle;
          else if (tick) prev_q  <= in_val;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                     drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
  end

  sync_fifo_fwft #(
    .WIDTH($bits(delta_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .pop  (pop),
    .din  (entry_in),
    .dout (entry_out),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Head is forced to zero when empty so stale RAM never leaks out.
  assign out_valid = !fifo_empty;
  assign out_delta = fifo_empty ? '0 : entry_out.delta;
  assign out_cross = fifo_empty ? 1'b0 : entry_out.cross_flag;
  assign full      = fifo_full;
  assign drop_cnt  = drop_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_acc_delta_sampler.sv
// Scoreboard bench: one sampler with SAMPLE_DIV=4 (ramp) and one with SAMPLE_DIV=1 (the rest).
module tb_acc_delta_sampler;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [31:0] in_val4 = '0, thr4 = '0, dl4;
  logic        en4 = 1'b0, rdy4 = 1'b0, v4, cr4, full4;
  logic [15:0] drop4;
  logic [1:0]  st4;

  logic [31:0] in_val1 = '0, thr1 = '0, dl1;
  logic        en1 = 1'b0, rdy1 = 1'b0, v1, cr1, full1;
  logic [15:0] drop1;
  logic [1:0]  st1;

  int checks = 0;
  int failures = 0;
  logic [32:0] q4[$];
  logic [32:0] q1[$];

  acc_delta_sampler #(.WIDTH(32), .DEPTH(4), .SAMPLE_DIV(4)) u_div4 (
    .CLK(CLK), .RST(RST), .in_val(in_val4), .enable(en4), .threshold(thr4),
    .out_valid(v4), .out_ready(rdy4), .out_delta(dl4), .out_cross(cr4),
    .full(full4), .drop_cnt(drop4), .state(st4)
  );

  acc_delta_sampler #(.WIDTH(32), .DEPTH(4), .SAMPLE_DIV(1)) u_div1 (
    .CLK(CLK), .RST(RST), .in_val(in_val1), .enable(en1), .threshold(thr1),
    .out_valid(v1), .out_ready(rdy1), .out_delta(dl1), .out_cross(cr1),
    .full(full1), .drop_cnt(drop1), .state(st1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitors: every accepted head must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && v4 && rdy4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d4_pop got=%0h required=no_entry", {cr4, dl4});
      end else chk("d4_pop", 64'({cr4, dl4}), 64'(q4.pop_front()));
    end
  end

  always @(negedge CLK) begin
    if (!RST && v1 && rdy1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d1_pop got=%0h required=no_entry", {cr1, dl1});
      end else chk("d1_pop", 64'({cr1, dl1}), 64'(q1.pop_front()));
    end
  end

  initial begin
    // Power-up reset
    cyc(3);
    chk("rst_valid4", 64'(v4), 64'd0);
    chk("rst_full4", 64'(full4), 64'd0);
    chk("rst_drop4", 64'(drop4), 64'd0);
    chk("rst_state4", 64'(st4), 64'd0);
    chk("rst_valid1", 64'(v1), 64'd0);
    chk("rst_state1", 64'(st1), 64'd0);
    RST = 1'b0;

    // Ramp +3/cycle, SAMPLE_DIV=4: ticks at edges 3,7,11,15,19; first primes.
    rdy4 = 1'b1;
    repeat (4) q4.push_back({1'b0, 32'd12});
    en4 = 1'b1;
    in_val4 = 32'd100;
    for (int i = 0; i < 22; i++) begin
      cyc(1);
      in_val4 = in_val4 + 32'd3;
      if (i == 0) chk("ramp_prime_state", 64'(st4), 64'd1);
    end
    en4 = 1'b0;
    cyc(3);
    chk("ramp_drained", 64'(q4.size()), 64'd0);
    chk("ramp_idle", 64'(st4), 64'd0);

    // Wrap: FFFF_FFFE then 3 -> delta 5, no crossing at threshold 0.
    rdy1 = 1'b1;
    en1 = 1'b1;
    cyc(1);
    chk("wrap_prime_state", 64'(st1), 64'd1);
    in_val1 = 32'hFFFF_FFFE;
    cyc(1);
    chk("wrap_run_state", 64'(st1), 64'd2);
    chk("wrap_no_push_on_prime", 64'(v1), 64'd0);
    in_val1 = 32'd3;
    q1.push_back({1'b0, 32'd5});
    cyc(1);
    chk("wrap_latency_valid", 64'(v1), 64'd1);
    en1 = 1'b0;
    cyc(1);
    chk("wrap_idle", 64'(st1), 64'd0);
    cyc(1);

    // Crossing at threshold 100: 90 -> 110 crosses, 110 -> 130 does not.
    thr1 = 32'd100;
    en1 = 1'b1;
    cyc(1);
    in_val1 = 32'd90;
    cyc(1);
    in_val1 = 32'd110;
    q1.push_back({1'b1, 32'd20});
    cyc(1);
    in_val1 = 32'd130;
    q1.push_back({1'b0, 32'd20});
    cyc(1);
    en1 = 1'b0;
    cyc(2);
    chk("cross_drained", 64'(q1.size()), 64'd0);

    // Backpressure: prime + 7 RUN ticks, 4 stored, 3 dropped.
    rdy1 = 1'b0;
    thr1 = 32'd0;
    en1 = 1'b1;
    cyc(1);
    in_val1 = 32'd10;
    cyc(1);
    for (int i = 1; i <= 7; i++) begin
      in_val1 = 32'(10 + 5 * i);
      if (i <= 4) q1.push_back({1'b0, 32'd5});
      cyc(1);
      if (i == 4) begin
        chk("bp_full_after_4", 64'(full1), 64'd1);
        chk("bp_no_drop_yet", 64'(drop1), 64'd0);
      end
    end
    en1 = 1'b0;
    cyc(1);
    chk("bp_drop_cnt", 64'(drop1), 64'd3);
    chk("bp_full_kept", 64'(full1), 64'd1);
    chk("bp_idle", 64'(st1), 64'd0);
    rdy1 = 1'b1;
    cyc(5);
    chk("bp_drained", 64'(q1.size()), 64'd0);
    chk("bp_empty", 64'(v1), 64'd0);

    // Full push+pop, then re-enable must re-prime.
    rdy1 = 1'b0;
    en1 = 1'b1;
    cyc(1);
    in_val1 = 32'd1000;
    cyc(1);
    for (int i = 1; i <= 4; i++) begin
      in_val1 = 32'(1000 + 7 * i);
      q1.push_back({1'b0, 32'd7});
      cyc(1);
    end
    chk("pp_full_before", 64'(full1), 64'd1);
    rdy1 = 1'b1;
    in_val1 = 32'd1035;
    q1.push_back({1'b0, 32'd7});
    cyc(1);
    chk("pp_full_stays", 64'(full1), 64'd1);
    chk("pp_drop_unchanged", 64'(drop1), 64'd3);
    en1 = 1'b0;
    cyc(1);
    chk("toggle_idle", 64'(st1), 64'd0);
    en1 = 1'b1;
    in_val1 = 32'd5000;
    cyc(1);
    chk("toggle_prime", 64'(st1), 64'd1);
    cyc(1);
    chk("toggle_run", 64'(st1), 64'd2);
    in_val1 = 32'd5004;
    q1.push_back({1'b0, 32'd4});
    cyc(1);
    en1 = 1'b0;
    cyc(8);
    chk("toggle_drained", 64'(q1.size()), 64'd0);

    // Mid-stream reset with a full queue and pending drops.
    rdy1 = 1'b0;
    en1 = 1'b1;
    cyc(1);
    in_val1 = 32'd0;
    cyc(1);
    for (int i = 1; i <= 6; i++) begin
      in_val1 = 32'(9 * i);
      cyc(1);
    end
    chk("mid_state_run", 64'(st1), 64'd2);
    chk("mid_full", 64'(full1), 64'd1);
    chk("mid_drop_cnt", 64'(drop1), 64'd5);
    RST = 1'b1;
    cyc(1);
    chk("mid_rst_valid", 64'(v1), 64'd0);
    chk("mid_rst_full", 64'(full1), 64'd0);
    chk("mid_rst_drop", 64'(drop1), 64'd0);
    chk("mid_rst_state", 64'(st1), 64'd0);
    cyc(2);
    RST = 1'b0;
    en1 = 1'b0;
    cyc(1);
    chk("post_rst_valid", 64'(v1), 64'd0);
    chk("post_rst_state", 64'(st1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
